// File: rtl/cpuc_grid_seq.sv
// cpuc_grid_seq: self-sequencing register/adder/compare grid run from a step memory.
// Build option: CPUC_GRID_SIGNED_CMP_EN makes the '>' units compare two's-complement.
module cpuc_grid_seq #(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_REGS   = 8,
  parameter int NUM_ADDERS = 2,
  parameter int NUM_CMP    = 1,
  parameter int NUM_EQUAL  = 1,
  parameter int CFG_DEPTH  = 16,
  localparam int NUM_SRC   = NUM_REGS + NUM_ADDERS
                           + NUM_CMP + NUM_EQUAL,
  localparam int SRC_W     = $clog2(NUM_SRC),
  localparam int REG_W     = $clog2(NUM_REGS),
  localparam int NUM_FLAGS = NUM_CMP + NUM_EQUAL,
  localparam int FLAG_W    = (NUM_FLAGS > 1)
                           ? $clog2(NUM_FLAGS) : 1,
  localparam int STEP_W    = $clog2(CFG_DEPTH),
  localparam int NUM_UNITS = NUM_ADDERS + NUM_FLAGS,
  localparam int CFG_W     = NUM_REGS * (1 + SRC_W)
                           + 2 * REG_W * NUM_UNITS
                           + 1 + FLAG_W + STEP_W + 1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         cfg_we,
  input  logic [STEP_W-1:0]            cfg_addr,
  input  logic [CFG_W-1:0]             cfg_wdata,
  output logic                         cfg_err,
  input  logic                         start,
  input  logic                         stop,
  output logic                         busy,
  output logic                         done,
  output logic [STEP_W-1:0]            step,
  output logic [NUM_REGS*DATA_WIDTH-1:0] reg_outputs
);

  localparam int REG_F   = 1 + SRC_W;
  localparam int UNIT_B  = NUM_REGS * REG_F;
  localparam int BR_EN   = UNIT_B + 2 * REG_W * NUM_UNITS;
  localparam int BR_FLAG = BR_EN + 1;
  localparam int BR_TGT  = BR_FLAG + FLAG_W;
  localparam int HALT    = BR_TGT + STEP_W;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t                state_q;
  state_t                state_n;
  logic [STEP_W-1:0]     step_q;
  logic [STEP_W-1:0]     step_n;
  logic                  done_q;
  logic                  done_n;
  logic                  cfg_err_q;
  logic                  commit;

  logic [CFG_W-1:0]      cfg_mem [CFG_DEPTH];
  logic [CFG_W-1:0]      word;

  logic [DATA_WIDTH-1:0] regs_q  [NUM_REGS];
  logic [DATA_WIDTH-1:0] opa     [NUM_UNITS];
  logic [DATA_WIDTH-1:0] opb     [NUM_UNITS];
  logic [DATA_WIDTH-1:0] src_val [NUM_SRC];
  logic [DATA_WIDTH-1:0] wval    [NUM_REGS];
  logic [NUM_REGS-1:0]   wen;
  logic [NUM_FLAGS-1:0]  flags;
  logic                  flag_sel;

  function automatic logic cmp_gt(
    input logic [DATA_WIDTH-1:0] a,
    input logic [DATA_WIDTH-1:0] b
  );
`ifdef CPUC_GRID_SIGNED_CMP_EN
    return $signed(a) > $signed(b);
`else
    return a > b;
`endif
  endfunction

  assign word = cfg_mem[step_q];

  // unit operand muxes; select codes past the last register read 0
  always_comb begin
    for (int u = 0; u < NUM_UNITS; u++) begin
      opa[u] = '0;
      opb[u] = '0;
      for (int r = 0; r < NUM_REGS; r++) begin
        if (word[UNIT_B+2*REG_W*u +: REG_W] == REG_W'(r))
          opa[u] = regs_q[r];
        if (word[UNIT_B+2*REG_W*u+REG_W +: REG_W] == REG_W'(r))
          opb[u] = regs_q[r];
      end
    end
  end

  // source bus: regs, then adders, then '>' units, then '==' units
  always_comb begin
    flags = '0;
    for (int r = 0; r < NUM_REGS; r++)
      src_val[r] = regs_q[r];
    for (int a = 0; a < NUM_ADDERS; a++)
      src_val[NUM_REGS+a] = opa[a] + opb[a];
    for (int c = 0; c < NUM_CMP; c++) begin
      flags[c] = cmp_gt(opa[NUM_ADDERS+c],
                        opb[NUM_ADDERS+c]);
      src_val[NUM_REGS+NUM_ADDERS+c] =
        DATA_WIDTH'(flags[c]);
    end
    for (int e = 0; e < NUM_EQUAL; e++) begin
      flags[NUM_CMP+e] =
        (opa[NUM_ADDERS+NUM_CMP+e] ==
         opb[NUM_ADDERS+NUM_CMP+e]);
      src_val[NUM_REGS+NUM_ADDERS+NUM_CMP+e] =
        DATA_WIDTH'(flags[NUM_CMP+e]);
    end
  end

  // per-register write data; an unused source code writes 0
  always_comb begin
    for (int i = 0; i < NUM_REGS; i++) begin
      wen[i]  = word[i*REG_F];
      wval[i] = '0;
      for (int s = 0; s < NUM_SRC; s++)
        if (word[i*REG_F+1 +: SRC_W] == SRC_W'(s))
          wval[i] = src_val[s];
    end
  end

  // branch flag select; out-of-range index reads as 0
  always_comb begin
    flag_sel = 1'b0;
    for (int f = 0; f < NUM_FLAGS; f++)
      if (word[BR_FLAG +: FLAG_W] == FLAG_W'(f))
        flag_sel = flags[f];
  end

  // sequencer next state: stop beats commit, halt beats branch
  always_comb begin
    state_n = state_q;
    step_n  = step_q;
    commit  = 1'b0;
    done_n  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start && !stop) begin
          state_n = RUN;
          step_n  = '0;
        end
      end
      RUN: begin
        if (stop) begin
          state_n = IDLE;
        end else begin
          commit = 1'b1;
          if (word[HALT]) begin
            state_n = IDLE;
            done_n  = 1'b1;
          end else if (word[BR_EN] && flag_sel) begin
            step_n = word[BR_TGT +: STEP_W];
          end else begin
            step_n = step_q + 1'b1;
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // sequencer state, done pulse and dropped-write flag
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      step_q    <= '0;
      done_q    <= 1'b0;
      cfg_err_q <= 1'b0;
    end else begin
      state_q   <= state_n;
      step_q    <= step_n;
      done_q    <= done_n;
      cfg_err_q <= cfg_we && (state_q == RUN);
    end
  end

  // step memory accepts writes only while idle
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int d = 0; d < CFG_DEPTH; d++)
        cfg_mem[d] <= '0;
    end else if (cfg_we && (state_q == IDLE)) begin
      cfg_mem[cfg_addr] <= cfg_wdata;
    end
  end

  // register bank commits the current step's writes
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++)
        regs_q[i] <= '0;
    end else if (commit) begin
      for (int i = 0; i < NUM_REGS; i++)
        if (wen[i])
          regs_q[i] <= wval[i];
    end
  end

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_out
    assign reg_outputs[g*DATA_WIDTH +: DATA_WIDTH] =
      regs_q[g];
  end

  assign busy    = (state_q == RUN);
  assign done    = done_q;
  assign step    = step_q;
  assign cfg_err = cfg_err_q;

endmodule
